aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_sbox.sv | 47 ++++
 rtl/aes_key_expand.sv | 113 +++++++++++
 tb/tb_aes_key_expand.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 key schedule shared definitions: widths, round count, Rcon table, FSM states.
// No logic of its own; latency and backpressure are properties of the users.
// Imported by aes_key_expand; the S-box lives in aes_sbox so the cipher core can share it.
package aes_pkg;

  localparam int KEY_L  = 128;  // cipher key width (AES-128 only)
  localparam int DATA_W = 128;  // round key / state width
  localparam int NR     = 10;   // number of rounds for AES-128

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  // Round constant for round n (1..10); unused indices return 0.
  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: byte_val - byte to substitute; sub_val - S-box image of byte_val.
module aes_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  always_comb begin
    inv = 8'h01;
    sq  = byte_val;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  assign sub_val = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: accepts a cipher key and iteratively builds all 11 round keys.
// Latency: one round key per cycle, keys_valid high in the cycle after the 10th edge; reads 1 cycle.
// Backpressure: key_ready low while expanding; key_valid is ignored until IDLE/DONE.
// Ports: clk, reset_n (async, active-low); key_valid/cipher_key/key_ready key intake;
//        keys_valid schedule complete; round_idx selects round_key (registered, 0 for 11..15).
module aes_key_expand #(
  parameter int KEY_L  = aes_pkg::KEY_L,   // only 128 is supported
  parameter int DATA_W = aes_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_valid,
  input  logic [KEY_L-1:0]  cipher_key,
  output logic              key_ready,
  output logic              keys_valid,
  input  logic [3:0]        round_idx,
  output logic [DATA_W-1:0] round_key
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NR);

  ks_state_t         state;
  ks_state_t         state_nxt;
  logic              accept;
  logic [3:0]        cnt;          // index of the round key produced on this edge

  logic [DATA_W-1:0] rk [0:NR];    // round-key storage, intentionally not reset
  logic [DATA_W-1:0] cur_key;      // rk[cnt-1], kept locally to avoid a read mux
  logic [DATA_W-1:0] nxt_key;

  logic [31:0]       w0, w1, w2, w3;
  logic [31:0]       rot_w;
  logic [31:0]       sub_w;
  logic [31:0]       temp;
  logic [31:0]       n0, n1, n2, n3;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b1;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (key_valid) begin
          accept    = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        key_ready = 1'b0;
        if (cnt == LAST_RND) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Leaving DONE on a re-key drops this on the accepting edge.
  assign keys_valid = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               cnt <= 4'd0;
    else if (accept)            cnt <= 4'd1;
    else if (state == EXPAND)   cnt <= cnt + 4'd1;
  end

  // ---------------------------------------------------------- next round key
  assign w0 = cur_key[127:96];
  assign w1 = cur_key[95:64];
  assign w2 = cur_key[63:32];
  assign w3 = cur_key[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .byte_val (rot_w[8*g +: 8]),
      .sub_val  (sub_w[8*g +: 8])
    );
  end

  assign temp    = sub_w ^ {rcon(cnt), 24'h000000};
  assign n0      = w0 ^ temp;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign nxt_key = {n0, n1, n2, n3};

  // ----------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (accept) begin
      rk[0]   <= cipher_key;
      cur_key <= cipher_key;
    end else if (state == EXPAND) begin
      rk[cnt] <= nxt_key;
      cur_key <= nxt_key;
    end
  end

  // Read port runs every cycle regardless of FSM state; reads same-edge writes as old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  round_key <= '0;
    else if (round_idx <= LAST_RND) round_key <= rk[round_idx];
    else                           round_key <= '0;
  end

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         key_valid;
  logic [127:0] cipher_key;
  logic         key_ready;
  logic         keys_valid;
  logic [3:0]   round_idx;
  logic [127:0] round_key;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .cipher_key (cipher_key),
    .key_ready  (key_ready),
    .keys_valid (keys_valid),
    .round_idx  (round_idx),
    .round_key  (round_key)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic [7:0]   sbox_tab [0:255];
  logic [127:0] model_rk [0:10];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // Walks GF(2^8) with generator 3 and its inverse in lockstep to tabulate the S-box.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tab[p] = x ^ 8'h63;
    end
    sbox_tab[0] = 8'h63;
  endtask

  // Textbook word-array expansion w[0..43].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ------------------------------------------------------------------ helpers
  task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
    round_idx = idx;
    @(posedge clk); #1;
    v = round_key;
  endtask

  // Offers key, checks handshake and keys_valid timing; optionally holds key_valid
  // high with another key during the expansion.
  task automatic run_expand(input logic [127:0] key, input bit hold_other,
                            input logic [127:0] other);
    int  g;
    bit  ok;
    g = 0;
    while (!key_ready && g < 30) begin
      @(posedge clk); #1;
      g++;
    end
    chk("key_ready_before_accept", key_ready, 1);
    key_valid  = 1'b1;
    cipher_key = key;
    @(posedge clk); #1;                       // acceptance edge T
    chk("keys_valid_low_after_accept", keys_valid, 0);
    chk("key_ready_low_in_expand", key_ready, 0);
    if (hold_other) cipher_key = other;
    else            key_valid  = 1'b0;
    ok = 1'b1;
    for (int e = 1; e < 10; e++) begin
      @(posedge clk); #1;
      if (keys_valid !== 1'b0 || key_ready !== 1'b0) ok = 1'b0;
    end
    key_valid = 1'b0;
    chk("keys_valid_low_T1_T9", ok, 1);
    @(posedge clk); #1;                       // edge T+10
    chk("keys_valid_high_T10", keys_valid, 1);
  endtask

  task automatic check_all(input string tag);
    logic [127:0] v;
    for (int r = 0; r <= 10; r++) begin
      read_rk(4'(r), v);
      chk($sformatf("%s_rk%0d", tag, r), v, model_rk[r]);
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK1_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] v;
    logic [127:0] rkey;

    vecs[0].key = KEY_A1;
    vecs[0].rk1 = RK1_A1;
    vecs[0].rk10 = RK10_A1;
    vecs[1].key = KEY_C1;
    vecs[1].rk1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    vecs[1].rk10 = RK10_C1;
    vecs[2].key = 128'h0;
    vecs[2].rk1 = 128'h62636363626363636263636362636363;
    vecs[2].rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    build_sbox();

    // Reset state
    reset_n    = 1'b0;
    key_valid  = 1'b0;
    cipher_key = '0;
    round_idx  = 4'd0;
    #12;
    chk("reset_round_key", round_key, 0);
    chk("reset_keys_valid", keys_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_key_ready", key_ready, 1);

    // Known-answer vectors, each checked against the constants and the model
    for (int i = 0; i < 3; i++) begin
      model_expand(vecs[i].key);
      run_expand(vecs[i].key, 1'b0, '0);
      read_rk(4'd0, v);  chk($sformatf("vec%0d_rk0", i), v, vecs[i].key);
      read_rk(4'd1, v);  chk($sformatf("vec%0d_rk1", i), v, vecs[i].rk1);
      read_rk(4'd10, v); chk($sformatf("vec%0d_rk10", i), v, vecs[i].rk10);
      check_all($sformatf("vec%0d_model", i));
    end

    // key_valid held with a different key during expansion is ignored
    run_expand(KEY_A1, 1'b1, KEY_C1);
    read_rk(4'd10, v); chk("hold_rk10", v, RK10_A1);
    read_rk(4'd1, v);  chk("hold_rk1", v, RK1_A1);

    // Re-key from DONE
    run_expand(KEY_C1, 1'b0, '0);
    read_rk(4'd10, v); chk("rekey_rk10", v, RK10_C1);

    // Reset in the middle of an expansion
    round_idx  = 4'd0;
    key_valid  = 1'b1;
    cipher_key = KEY_A1;
    @(posedge clk); #1;                       // T
    key_valid = 1'b0;
    repeat (4) @(posedge clk);                // T+4
    @(posedge clk); #1;                       // T+5
    chk("pre_reset_round_key", round_key, KEY_A1);
    reset_n = 1'b0;
    #1;
    chk("midreset_keys_valid", keys_valid, 0);
    chk("midreset_round_key", round_key, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midreset_key_ready", key_ready, 1);
    @(posedge clk); #1;
    chk("after_reset_keys_valid", keys_valid, 0);
    run_expand(KEY_A1, 1'b0, '0);
    read_rk(4'd10, v); chk("after_reset_rk10", v, RK10_A1);

    // Out-of-range indices read as zero
    read_rk(4'd12, v); chk("idx12_zero", v, 0);
    read_rk(4'd15, v); chk("idx15_zero", v, 0);
    read_rk(4'd10, v); chk("idx10_after_oor", v, RK10_A1);

    // Randomised keys against the model
    for (int n = 0; n < 12; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rkey);
      run_expand(rkey, 1'b0, '0);
      check_all($sformatf("rand%0d", n));
      read_rk(4'($urandom_range(11, 15)), v);
      chk($sformatf("rand%0d_oor", n), v, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
